// File: rtl/niosqsys_oci_dct_sequencer.sv
// niosqsys_oci_dct_sequencer
//   Packs 2-bit trace atoms from the CPU trace port into a 30-bit DCT
//   buffer, hands each full or flushed frame to the OCI trace FIFO with a
//   valid/ready handshake, and runs the end-of-test flush.
//
// Ports
//   clk, reset        clock (rising edge) and asynchronous active-high reset
//   atom_valid/ready  trace atom handshake, atom_data is the 2-bit atom
//   test_ending       level flush request, sampled every cycle
//   frm_valid/ready   frame handshake towards the trace FIFO
//   frm_data/count    frame payload and atom count (zero when no frame)
//   dct_buffer/count  live packing buffer and atom count (monitor taps)
//   test_has_ended    flush complete, sticky until reset
//   drop_count        atoms refused while not filling
//
// Build option
//   OCI_DCT_DROP_CNT_EN  when defined, drop_count is a saturating 8-bit
//                        counter; otherwise drop_count is tied to zero.
module niosqsys_oci_dct_sequencer #(
  parameter int ATOM_W = 2,
  parameter int ATOMS  = 15,
  parameter int CNT_W  = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      atom_valid,
  input  logic [ATOM_W-1:0]         atom_data,
  output logic                      atom_ready,
  input  logic                      test_ending,
  output logic                      frm_valid,
  input  logic                      frm_ready,
  output logic [ATOM_W*ATOMS-1:0]   frm_data,
  output logic [CNT_W-1:0]          frm_count,
  output logic [ATOM_W*ATOMS-1:0]   dct_buffer,
  output logic [CNT_W-1:0]          dct_count,
  output logic                      test_has_ended,
  output logic [7:0]                drop_count
);

  localparam int BUF_W = ATOM_W * ATOMS;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(ATOMS);

  typedef enum logic [1:0] {
    ST_FILL,
    ST_EMIT,
    ST_DONE
  } state_t;

  state_t             state_reg, state_next;
  logic [BUF_W-1:0]   buf_reg, buf_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               pend_reg, pend_next;
  // Holds atom_ready low for the first cycle after reset release.
  logic               alive_reg;
  logic               accept;

  assign atom_ready     = alive_reg && (state_reg == ST_FILL);
  assign accept         = atom_valid && atom_ready;
  assign frm_valid      = (state_reg == ST_EMIT);
  assign frm_data       = frm_valid ? buf_reg : '0;
  assign frm_count      = frm_valid ? cnt_reg : '0;
  assign dct_buffer     = buf_reg;
  assign dct_count      = cnt_reg;
  assign test_has_ended = (state_reg == ST_DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_FILL;
      buf_reg   <= '0;
      cnt_reg   <= '0;
      pend_reg  <= 1'b0;
      alive_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      buf_reg   <= buf_next;
      cnt_reg   <= cnt_next;
      pend_reg  <= pend_next;
      alive_reg <= 1'b1;
    end
  end

  always_comb begin
    state_next = state_reg;
    buf_next   = buf_reg;
    cnt_next   = cnt_reg;
    pend_next  = pend_reg;
    case (state_reg)
      ST_FILL: begin
        if (test_ending) pend_next = 1'b1;
        // An atom arriving with the flush request is packed first, so the
        // flushed frame includes it.
        for (int i = 0; i < ATOMS; i++) begin
          if (accept && cnt_reg == CNT_W'(i)) begin
            buf_next[i*ATOM_W +: ATOM_W] = atom_data;
          end
        end
        if (accept) cnt_next = cnt_reg + CNT_W'(1);
        if (cnt_next == CNT_FULL) begin
          state_next = ST_EMIT;
        end else if (test_ending || pend_reg) begin
          // Never hand an empty frame to the FIFO.
          state_next = (cnt_next != '0) ? ST_EMIT : ST_DONE;
        end
      end
      ST_EMIT: begin
        if (test_ending) pend_next = 1'b1;
        if (frm_ready) begin
          buf_next   = '0;
          cnt_next   = '0;
          state_next = (pend_reg || test_ending) ? ST_DONE : ST_FILL;
        end
      end
      ST_DONE: begin
        state_next = ST_DONE;
      end
      default: begin
        state_next = ST_FILL;
      end
    endcase
  end

`ifdef OCI_DCT_DROP_CNT_EN
  logic [7:0] drop_reg;

  // Any offered atom outside FILL is refused; the counter sticks at 255.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_reg <= 8'd0;
    end else if (atom_valid && state_reg != ST_FILL && drop_reg != 8'hFF) begin
      drop_reg <= drop_reg + 8'd1;
    end
  end

  assign drop_count = drop_reg;
`else
  assign drop_count = 8'd0;
`endif

endmodule

// File: tb/tb_niosqsys_oci_dct_sequencer.sv
module tb_niosqsys_oci_dct_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        atom_valid = 1'b0;
  logic [1:0]  atom_data = 2'd0;
  logic        atom_ready;
  logic        test_ending = 1'b0;
  logic        frm_valid;
  logic        frm_ready = 1'b0;
  logic [29:0] frm_data;
  logic [3:0]  frm_count;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        test_has_ended;
  logic [7:0]  drop_count;

  int n_cmp = 0;
  int n_err = 0;

  niosqsys_oci_dct_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .atom_valid     (atom_valid),
    .atom_data      (atom_data),
    .atom_ready     (atom_ready),
    .test_ending    (test_ending),
    .frm_valid      (frm_valid),
    .frm_ready      (frm_ready),
    .frm_data       (frm_data),
    .frm_count      (frm_count),
    .dct_buffer     (dct_buffer),
    .dct_count      (dct_count),
    .test_has_ended (test_has_ended),
    .drop_count     (drop_count)
  );

  always #5 clk = ~clk;

  // Reference model: the frame being built is a queue of atoms; the packed
  // buffer is derived from it on demand.
  logic [1:0] mq[$];
  bit         m_emit  = 1'b0;   // frame is being offered to the FIFO
  bit         m_ended = 1'b0;   // flush finished
  bit         m_flush = 1'b0;   // a flush has been requested
  bit         m_live  = 1'b0;   // at least one clock since reset release
  int         m_drop  = 0;

  function automatic logic [29:0] packed_q();
    logic [29:0] p = '0;
    for (int i = 0; i < mq.size(); i++) p[2*i +: 2] = mq[i];
    return p;
  endfunction

  function automatic bit m_ready();
    return m_live && !m_emit && !m_ended;
  endfunction

`ifdef OCI_DCT_DROP_CNT_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      m_emit = 0; m_ended = 0; m_flush = 0; m_live = 0; m_drop = 0;
    end else begin
      bit acc;
      acc = atom_valid && m_ready();
      if (DROP_EN && atom_valid && (m_emit || m_ended) && m_drop < 255) m_drop++;
      if (test_ending && !m_ended) m_flush = 1;
      if (!m_ended) begin
        if (!m_emit) begin
          if (acc) mq.push_back(atom_data);
          if (mq.size() == 15) m_emit = 1;
          else if (m_flush) begin
            if (mq.size() > 0) m_emit = 1;
            else m_ended = 1;
          end
        end else if (frm_ready) begin
          mq.delete();
          m_emit = 0;
          if (m_flush) m_ended = 1;
        end
      end
      m_live = 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the clock edge.
  always @(negedge clk) begin
    chk("atom_ready",     32'(atom_ready),     32'(m_ready()));
    chk("frm_valid",      32'(frm_valid),      32'(m_emit));
    chk("frm_data",       32'(frm_data),       m_emit ? 32'(packed_q()) : 32'd0);
    chk("frm_count",      32'(frm_count),      m_emit ? 32'(mq.size()) : 32'd0);
    chk("dct_buffer",     32'(dct_buffer),     32'(packed_q()));
    chk("dct_count",      32'(dct_count),      32'(mq.size()));
    chk("test_has_ended", 32'(test_has_ended), 32'(m_ended));
    chk("drop_count",     32'(drop_count),     32'(m_drop));
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    cyc();
    reset = 1'b1;
    atom_valid = 0; test_ending = 0; frm_ready = 0;
    cyc();
    cyc();
    reset = 1'b0;
    chk("ready_low_after_release", 32'(atom_ready), 32'd0);
    cyc();
    chk("ready_high_one_cycle_later", 32'(atom_ready), 32'd1);
  endtask

  initial begin
    // Reset state
    cyc();
    chk("rst_frm_valid", 32'(frm_valid), 32'd0);
    chk("rst_atom_ready", 32'(atom_ready), 32'd0);
    chk("rst_dct_count", 32'(dct_count), 32'd0);
    do_reset();

    // Full frame of atoms 3,2,1,0,... with FIFO ready
    frm_ready = 1;
    for (int i = 0; i < 15; i++) begin
      atom_valid = 1; atom_data = 2'(3 - (i % 4));
      cyc();
      if (i == 13) chk("t1_no_valid_before_full", 32'(frm_valid), 32'd0);
    end
    atom_valid = 0;
    chk("t1_valid", 32'(frm_valid), 32'd1);
    chk("t1_count", 32'(frm_count), 32'd15);
    chk("t1_data", 32'(frm_data), 32'h1B1B1B1B);
    cyc();
    chk("t1_cleared", 32'(dct_count), 32'd0);
    chk("t1_back_to_fill", 32'(atom_ready), 32'd1);

    // Atoms 0,1,2,3,... with FIFO stalled for 10 cycles, atom_valid held
    frm_ready = 0;
    for (int i = 0; i < 15; i++) begin
      atom_valid = 1; atom_data = 2'(i % 4);
      cyc();
    end
    for (int j = 0; j < 10; j++) begin
      chk("t4_data_stable", 32'(frm_data), 32'h24E4E4E4);
      chk("t4_ready_low", 32'(atom_ready), 32'd0);
      cyc();
    end
    chk("t4_drop", 32'(drop_count), DROP_EN ? 32'd10 : 32'd0);
    atom_valid = 0; frm_ready = 1;
    cyc();

    // Three atoms then flush
    for (int i = 0; i < 3; i++) begin
      atom_valid = 1; atom_data = 2'(3 - i);
      cyc();
    end
    atom_valid = 0; test_ending = 1;
    cyc();
    test_ending = 0;
    chk("t2_count", 32'(frm_count), 32'd3);
    chk("t2_data", 32'(frm_data), 32'h0000001B);
    cyc();
    chk("t2_ended", 32'(test_has_ended), 32'd1);
    chk("t2_ready_low", 32'(atom_ready), 32'd0);

    // Drop counter saturation while terminal
    atom_valid = 1;
    repeat (260) cyc();
    atom_valid = 0;
    chk("drop_saturate", 32'(drop_count), DROP_EN ? 32'd255 : 32'd0);

    // Flush with empty buffer
    do_reset();
    test_ending = 1;
    cyc();
    test_ending = 0;
    chk("t3_ended", 32'(test_has_ended), 32'd1);
    chk("t3_no_frame", 32'(frm_valid), 32'd0);

    // Atom and flush in the same cycle at count 4
    do_reset();
    for (int i = 0; i < 4; i++) begin
      atom_valid = 1; atom_data = 2'd2;
      cyc();
    end
    atom_data = 2'd3; test_ending = 1;
    cyc();
    atom_valid = 0; test_ending = 0;
    chk("t5_count", 32'(frm_count), 32'd5);
    chk("t5_data", 32'(frm_data), 32'h000003AA);
    frm_ready = 1;
    cyc();
    chk("t5_ended", 32'(test_has_ended), 32'd1);

    // Reset pulse in the middle of a stalled frame
    do_reset();
    for (int i = 0; i < 15; i++) begin
      atom_valid = 1; atom_data = 2'(i % 4);
      cyc();
    end
    atom_valid = 0;
    chk("t6_in_emit", 32'(frm_valid), 32'd1);
    #1 reset = 1;
    #1;
    chk("t6_valid_cleared", 32'(frm_valid), 32'd0);
    chk("t6_count_cleared", 32'(dct_count), 32'd0);
    cyc();
    reset = 0;
    cyc();
    atom_valid = 1; atom_data = 2'd2;
    cyc();
    atom_valid = 0;
    chk("t6_resume_count", 32'(dct_count), 32'd1);
    chk("t6_resume_buf", 32'(dct_buffer), 32'd2);

    // Randomized traffic against the model
    for (int n = 0; n < 4000; n++) begin
      reset       = ($urandom_range(0, 399) == 0) || (m_ended && $urandom_range(0, 7) == 0);
      atom_valid  = ($urandom_range(0, 3) != 0);
      atom_data   = 2'($urandom_range(0, 3));
      frm_ready   = ($urandom_range(0, 2) != 0);
      test_ending = ($urandom_range(0, 99) == 0);
      cyc();
    end
    reset = 0; atom_valid = 0; test_ending = 0;
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
